// File: rtl/halt_ctrl.sv
// End-of-run sequencer for the single-issue NPC core: detects ebreak, illegal
// instructions and commit hangs, stalls the core, drains, then latches a sticky halt.
module halt_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int WDOG_CYCLES  = 1048576,
    parameter int CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit_valid,
    input  logic [31:0]      commit_inst,
    input  logic [31:0]      commit_pc,
    input  logic [31:0]      gpr10,
    input  logic             inv_inst,
    output logic             core_stall,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [31:0]      exit_code,
    output logic [31:0]      halt_pc,
    output logic             good_trap,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int WW = $clog2(WDOG_CYCLES);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [31:0]   EBREAK     = 32'h0010_0073;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
    localparam logic [1:0] CAUSE_WDOG    = 2'd3;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             halted_q, halted_d;
    logic [1:0]       cause_q, cause_d;
    logic [31:0]      exit_q, exit_d;
    logic [31:0]      hpc_q, hpc_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic trig_ill, trig_ebr, trig_wdg, trigger;

    always_comb begin
        trig_ill = (state_q == S_RUN) && commit_valid && inv_inst;
        trig_ebr = (state_q == S_RUN) && commit_valid && !inv_inst && (commit_inst == EBREAK);
        // A commit landing on the threshold cycle cancels the watchdog.
        trig_wdg = (state_q == S_RUN) && !commit_valid && (wdog_q == WDOG_LAST);
        trigger  = trig_ill || trig_ebr || trig_wdg;
    end

    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        cause_d   = cause_q;
        exit_d    = exit_q;
        hpc_d     = hpc_q;
        last_pc_d = last_pc_q;
        wdog_d    = wdog_q;
        drain_d   = drain_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;

        case (state_q)
            S_RUN: begin
                cycle_d = cycle_q + CNT_W'(1);
                if (commit_valid) begin
                    instret_d = instret_q + CNT_W'(1);
                    last_pc_d = commit_pc;
                    wdog_d    = '0;
                end else if (wdog_q != WDOG_LAST) begin
                    wdog_d = wdog_q + WW'(1);
                end

                if (trigger) begin
                    if (trig_ill) begin
                        cause_d = CAUSE_ILLEGAL;
                        exit_d  = commit_inst;
                        hpc_d   = commit_pc;
                    end else if (trig_ebr) begin
                        cause_d = CAUSE_EBREAK;
                        exit_d  = gpr10;
                        hpc_d   = commit_pc;
                    end else begin
                        cause_d = CAUSE_WDOG;
                        exit_d  = 32'hFFFF_FFFF;
                        hpc_d   = last_pc_q;
                    end
                    drain_d = '0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                cycle_d = cycle_q + CNT_W'(1);
                if (drain_q == DRAIN_LAST) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: begin
                // HALT holds everything until reset.
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RUN;
            halted_q  <= 1'b0;
            cause_q   <= CAUSE_NONE;
            exit_q    <= '0;
            hpc_q     <= '0;
            last_pc_q <= '0;
            wdog_q    <= '0;
            drain_q   <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            cause_q   <= cause_d;
            exit_q    <= exit_d;
            hpc_q     <= hpc_d;
            last_pc_q <= last_pc_d;
            wdog_q    <= wdog_d;
            drain_q   <= drain_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign core_stall  = (state_q != S_RUN) || trigger;
    assign halted      = halted_q;
    assign halt_cause  = cause_q;
    assign exit_code   = exit_q;
    assign halt_pc     = hpc_q;
    assign good_trap   = halted_q && (cause_q == CAUSE_EBREAK) && (exit_q == 32'd0);
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: tb/tb_halt_ctrl.sv
// Bench for halt_ctrl: two instances (drain 2 and drain 0, watchdog 16) share stimulus
// and are checked every cycle against a run/drain/halt model plus literal expectations.
module tb_halt_ctrl;
    localparam int WDOG = 16;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ADDI   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_inst = '0;
    logic [31:0] commit_pc = '0;
    logic [31:0] gpr10 = '0;
    logic        inv_inst = 1'b0;

    logic        stall_o [2];
    logic        halted_o[2];
    logic [1:0]  cause_o [2];
    logic [31:0] exit_o  [2];
    logic [31:0] hpc_o   [2];
    logic        good_o  [2];
    logic [63:0] cyc_o   [2];
    logic [63:0] ret_o   [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    halt_ctrl #(.DRAIN_CYCLES(2), .WDOG_CYCLES(WDOG), .CNT_W(64)) u_dut0 (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_inst(commit_inst),
        .commit_pc(commit_pc), .gpr10(gpr10), .inv_inst(inv_inst),
        .core_stall(stall_o[0]), .halted(halted_o[0]), .halt_cause(cause_o[0]),
        .exit_code(exit_o[0]), .halt_pc(hpc_o[0]), .good_trap(good_o[0]),
        .cycle_cnt(cyc_o[0]), .instret_cnt(ret_o[0])
    );

    halt_ctrl #(.DRAIN_CYCLES(0), .WDOG_CYCLES(WDOG), .CNT_W(64)) u_dut1 (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_inst(commit_inst),
        .commit_pc(commit_pc), .gpr10(gpr10), .inv_inst(inv_inst),
        .core_stall(stall_o[1]), .halted(halted_o[1]), .halt_cause(cause_o[1]),
        .exit_code(exit_o[1]), .halt_pc(hpc_o[1]), .good_trap(good_o[1]),
        .cycle_cnt(cyc_o[1]), .instret_cnt(ret_o[1])
    );

    // ---------------- model: phase 0 running, 1 draining, 2 halted ----------------
    int          m_phase[2];
    int          m_left [2];
    int          m_idle [2];
    logic [31:0] m_last [2];
    int          m_cause[2];
    logic [31:0] m_exit [2];
    logic [31:0] m_hpc  [2];
    logic [63:0] m_cyc  [2];
    logic [63:0] m_ret  [2];

    function automatic int drain_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int model_trig(input int i);
        if (m_phase[i] != 0) return 0;
        if (commit_valid && inv_inst) return 2;
        if (commit_valid && commit_inst == EBREAK) return 1;
        if (!commit_valid && m_idle[i] == WDOG - 1) return 3;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0; m_left[i] = 0; m_idle[i] = 0; m_last[i] = '0;
                m_cause[i] = 0; m_exit[i] = '0; m_hpc[i] = '0; m_cyc[i] = '0; m_ret[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int t;
                t = model_trig(i);
                if (m_phase[i] != 2) m_cyc[i] = m_cyc[i] + 1;
                if (m_phase[i] == 0) begin
                    if (t == 1) begin m_exit[i] = gpr10; m_hpc[i] = commit_pc; end
                    if (t == 2) begin m_exit[i] = commit_inst; m_hpc[i] = commit_pc; end
                    if (t == 3) begin m_exit[i] = 32'hFFFF_FFFF; m_hpc[i] = m_last[i]; end
                    if (commit_valid) begin
                        m_ret[i] = m_ret[i] + 1;
                        m_last[i] = commit_pc;
                        m_idle[i] = 0;
                    end else if (m_idle[i] < WDOG - 1) begin
                        m_idle[i]++;
                    end
                    if (t != 0) begin
                        m_cause[i] = t;
                        m_left[i]  = drain_of(i);
                        m_phase[i] = (drain_of(i) == 0) ? 2 : 1;
                    end
                end else if (m_phase[i] == 1) begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_phase[i] = 2;
                end
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input int i);
        logic exp_halted;
        exp_halted = (m_phase[i] == 2);
        chk($sformatf("dut%0d.core_stall", i), 64'(stall_o[i]),
            64'((m_phase[i] != 0) || (model_trig(i) != 0)));
        chk($sformatf("dut%0d.halted", i), 64'(halted_o[i]), 64'(exp_halted));
        chk($sformatf("dut%0d.halt_cause", i), 64'(cause_o[i]), 64'(m_cause[i]));
        chk($sformatf("dut%0d.exit_code", i), 64'(exit_o[i]), 64'(m_exit[i]));
        chk($sformatf("dut%0d.halt_pc", i), 64'(hpc_o[i]), 64'(m_hpc[i]));
        chk($sformatf("dut%0d.good_trap", i), 64'(good_o[i]),
            64'(exp_halted && m_cause[i] == 1 && m_exit[i] == 32'd0));
        chk($sformatf("dut%0d.cycle_cnt", i), cyc_o[i], m_cyc[i]);
        chk($sformatf("dut%0d.instret_cnt", i), ret_o[i], m_ret[i]);
    endtask

    always @(negedge clk) begin
        check_model(0);
        check_model(1);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cv, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] a0, input logic inv);
        commit_valid = cv; commit_inst = inst; commit_pc = pc; gpr10 = a0; inv_inst = inv;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        step();
        do_reset();

        // Five addi then a clean ebreak.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, ADDI, 32'h8000_0000 + 32'(4 * k), 32'd7, 1'b0);
            step();
        end
        drive(1'b1, EBREAK, 32'h8000_0014, 32'd0, 1'b0);
        #2;
        chk("s1.stall_in_ebreak_cycle", 64'(stall_o[0]), 64'd1);
        step();
        idle();
        chk("s1.drain0_halted_next", 64'(halted_o[1]), 64'd1);
        chk("s1.drain2_not_halted_1", 64'(halted_o[0]), 64'd0);
        chk("s1.cause_valid_in_drain", 64'(cause_o[0]), 64'd1);
        step();
        chk("s1.drain2_not_halted_2", 64'(halted_o[0]), 64'd0);
        step();
        chk("s1.drain2_halted", 64'(halted_o[0]), 64'd1);
        chk("s1.cause", 64'(cause_o[0]), 64'd1);
        chk("s1.exit_code", 64'(exit_o[0]), 64'd0);
        chk("s1.halt_pc", 64'(hpc_o[0]), 64'h8000_0014);
        chk("s1.good_trap", 64'(good_o[0]), 64'd1);
        chk("s1.instret", ret_o[0], 64'd6);
        chk("s1.cycle_drain2", cyc_o[0], 64'd8);
        chk("s1.cycle_drain0", cyc_o[1], 64'd6);
        drive(1'b1, ADDI, 32'h8000_0018, 32'd0, 1'b0);
        step(); step();
        idle();
        chk("s1.instret_holds", ret_o[0], 64'd6);
        chk("s1.cycle_holds", cyc_o[0], 64'd8);

        // ebreak with non-zero exit value.
        do_reset();
        drive(1'b1, EBREAK, 32'h8000_0020, 32'd1, 1'b0);
        step(); idle(); step(); step();
        chk("s2.cause", 64'(cause_o[0]), 64'd1);
        chk("s2.exit_code", 64'(exit_o[0]), 64'd1);
        chk("s2.good_trap", 64'(good_o[0]), 64'd0);

        // Illegal instruction beats a later ebreak.
        do_reset();
        drive(1'b1, ADDI, 32'h8000_00FC, 32'd0, 1'b0);
        step();
        drive(1'b1, 32'hFFFF_FFFF, 32'h8000_0100, 32'd0, 1'b1);
        step();
        drive(1'b1, EBREAK, 32'h8000_0104, 32'd0, 1'b0);
        step(); idle(); step(); step();
        chk("s3.cause", 64'(cause_o[0]), 64'd2);
        chk("s3.exit_code", 64'(exit_o[0]), 64'hFFFF_FFFF);
        chk("s3.halt_pc", 64'(hpc_o[0]), 64'h8000_0100);
        chk("s3.instret", ret_o[0], 64'd2);
        chk("s3.halted", 64'(halted_o[0]), 64'd1);

        // Watchdog: fires 16 cycles after the last commit.
        do_reset();
        drive(1'b1, ADDI, 32'h8000_0040, 32'd0, 1'b0);
        step();
        idle();
        n = 0;
        while (n < 40) begin
            n++;
            #2;
            if (stall_o[0]) break;
            step();
        end
        chk("s4.wdog_latency", 64'(n), 64'd16);
        step(); step(); step();
        chk("s4.cause", 64'(cause_o[0]), 64'd3);
        chk("s4.exit_code", 64'(exit_o[0]), 64'hFFFF_FFFF);
        chk("s4.halt_pc", 64'(hpc_o[0]), 64'h8000_0040);
        chk("s4.halted", 64'(halted_o[0]), 64'd1);

        // Watchdog cancelled by a commit on the threshold cycle.
        do_reset();
        drive(1'b1, ADDI, 32'h8000_0040, 32'd0, 1'b0);
        step();
        idle();
        for (int k = 0; k < 15; k++) step();
        drive(1'b1, ADDI, 32'h8000_0044, 32'd0, 1'b0);
        #2;
        chk("s5.no_stall_on_threshold", 64'(stall_o[0]), 64'd0);
        step();
        idle();
        for (int k = 0; k < 4; k++) step();
        chk("s5.not_halted", 64'(halted_o[0]), 64'd0);
        chk("s5.cause_none", 64'(cause_o[0]), 64'd0);

        // Reset in the middle of DRAIN.
        do_reset();
        drive(1'b1, ADDI, 32'h8000_0000, 32'd0, 1'b0);
        step();
        drive(1'b1, EBREAK, 32'h8000_0004, 32'd0, 1'b0);
        step();
        idle();
        chk("s6.in_drain_stall", 64'(stall_o[0]), 64'd1);
        rst = 1'b1;
        #1;
        chk("s6.rst_stall", 64'(stall_o[0]), 64'd0);
        chk("s6.rst_cause", 64'(cause_o[0]), 64'd0);
        chk("s6.rst_exit", 64'(exit_o[0]), 64'd0);
        chk("s6.rst_pc", 64'(hpc_o[0]), 64'd0);
        chk("s6.rst_cycle", cyc_o[0], 64'd0);
        chk("s6.rst_instret", ret_o[0], 64'd0);
        chk("s6.rst_halted_d0", 64'(halted_o[1]), 64'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, ADDI, 32'h8000_0200 + 32'(4 * k), 32'd0, 1'b0);
            step();
        end
        idle();
        chk("s6.instret_after", ret_o[0], 64'd3);
        chk("s6.not_halted_after", 64'(halted_o[0]), 64'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
